// File: rtl/lap_uart_tx_if.sv
// Snapshot handshake between the stopwatch lap/split registers and the UART line formatter.
interface lap_uart_tx_if;
  logic        valid;
  logic        ready;
  logic [31:0] digits;

  modport master (output valid, output digits, input ready);
  modport slave  (input valid, input digits, output ready);
endinterface

// File: rtl/lap_uart_tx.sv
// Formats one BCD time snapshot as "HH:MM:SS.CC\r\n" and sends it on a UART 8N1 line.
// Define LAP_TX_PARITY_EN to append an even parity bit to every character.
module lap_uart_tx #(
  parameter int BASE_CLOCK = 100_000_000,
  parameter int BAUD       = 115_200
) (
  input  logic          clock,
  input  logic          reset,
  lap_uart_tx_if.slave  bus,
  output logic          tx,
  output logic          busy
);

  localparam int              CLKS_PER_BIT = BASE_CLOCK / BAUD;
  localparam int              CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LAST_CHAR    = 4'd12;

`ifdef LAP_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2:0]         bit_idx_reg, bit_idx_next;
  logic [3:0]         char_idx_reg, char_idx_next;
  logic [31:0]        digits_reg, digits_next;
  logic [7:0]         ascii_digit [8];
  logic [7:0]         char_byte;
  logic               bit_done;
  logic               tx_line;

  // Non-decimal nibbles are shown as '?' so a corrupt snapshot is visible on the host.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ascii
      logic [3:0] nibble;
      assign nibble          = digits_reg[gi*4 +: 4];
      assign ascii_digit[gi] = (nibble <= 4'd9) ? {4'h3, nibble} : 8'h3F;
    end
  endgenerate

  always_comb begin
    case (char_idx_reg)
      4'd0:    char_byte = ascii_digit[7];
      4'd1:    char_byte = ascii_digit[6];
      4'd2:    char_byte = 8'h3A;
      4'd3:    char_byte = ascii_digit[5];
      4'd4:    char_byte = ascii_digit[4];
      4'd5:    char_byte = 8'h3A;
      4'd6:    char_byte = ascii_digit[3];
      4'd7:    char_byte = ascii_digit[2];
      4'd8:    char_byte = 8'h2E;
      4'd9:    char_byte = ascii_digit[1];
      4'd10:   char_byte = ascii_digit[0];
      4'd11:   char_byte = 8'h0D;
      default: char_byte = 8'h0A;
    endcase
  end

  assign bit_done = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bit_idx_next  = bit_idx_reg;
    char_idx_next = char_idx_reg;
    digits_next   = digits_reg;
    tx_line       = 1'b1;

    if (state_reg != S_IDLE) begin
      cnt_next = bit_done ? '0 : cnt_reg + 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (bus.valid) begin
          state_next    = S_START;
          digits_next   = bus.digits;
          cnt_next      = '0;
          bit_idx_next  = '0;
          char_idx_next = '0;
        end
      end
      S_START: begin
        tx_line = 1'b0;
        if (bit_done) begin
          state_next   = S_DATA;
          bit_idx_next = '0;
        end
      end
      S_DATA: begin
        tx_line = char_byte[bit_idx_reg];
        if (bit_done) begin
          if (bit_idx_reg == 3'd7) begin
`ifdef LAP_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
`ifdef LAP_TX_PARITY_EN
      S_PARITY: begin
        tx_line = ^char_byte;
        if (bit_done) begin
          state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        tx_line = 1'b1;
        if (bit_done) begin
          // Next start bit follows the stop bit with no gap inside a frame.
          if (char_idx_reg < LAST_CHAR) begin
            char_idx_next = char_idx_reg + 4'd1;
            state_next    = S_START;
          end else begin
            char_idx_next = '0;
            state_next    = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      char_idx_reg <= '0;
      digits_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_idx_reg  <= bit_idx_next;
      char_idx_reg <= char_idx_next;
      digits_reg   <= digits_next;
    end
  end

  // Line level decodes registered state only, so an async reset forces idle-high at once.
  assign tx        = tx_line;
  assign bus.ready = (state_reg == S_IDLE);
  assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_lap_uart_tx.sv
// Scoreboard bench for lap_uart_tx: expected characters are queued when a snapshot is offered
// and popped as the serial line is decoded at exact bit boundaries.
module tb_lap_uart_tx;

  localparam int C = 10;
`ifdef LAP_TX_PARITY_EN
  localparam int BITS_PER_CHAR = 11;
`else
  localparam int BITS_PER_CHAR = 10;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic tx;
  logic busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   exp_q [$];
  logic [103:0] t2_bytes = 104'h31_32_3A_33_34_3A_35_36_2E_37_38_0D_0A;
  logic [103:0] t3_bytes = 104'h30_3F_3A_30_30_3A_30_30_2E_3F_39_0D_0A;

  lap_uart_tx_if bus ();

  lap_uart_tx #(
    .BASE_CLOCK (1_000_000),
    .BAUD       (100_000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] nib_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : 8'h3F;
  endfunction

  task automatic push_table(input logic [103:0] t);
    for (int i = 0; i < 13; i++) exp_q.push_back(t[103 - 8*i -: 8]);
  endtask

  task automatic push_model(input logic [31:0] d);
    exp_q.push_back(nib_ascii(d[31:28]));
    exp_q.push_back(nib_ascii(d[27:24]));
    exp_q.push_back(8'h3A);
    exp_q.push_back(nib_ascii(d[23:20]));
    exp_q.push_back(nib_ascii(d[19:16]));
    exp_q.push_back(8'h3A);
    exp_q.push_back(nib_ascii(d[15:12]));
    exp_q.push_back(nib_ascii(d[11:8]));
    exp_q.push_back(8'h2E);
    exp_q.push_back(nib_ascii(d[7:4]));
    exp_q.push_back(nib_ascii(d[3:0]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Offers d, waits (bounded) for acceptance; returns at the negedge of the first start-bit cycle.
  task automatic offer(input logic [31:0] d);
    int n = 0;
    @(negedge clock);
    bus.valid  = 1'b1;
    bus.digits = d;
    while (bus.ready !== 1'b1 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout: ready=%b after %0d cycles, required 1", bus.ready, n);
    end
    @(negedge clock);
    bus.valid  = 1'b0;
    bus.digits = $urandom;
    checks++;
    if (tx !== 1'b0 || bus.ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL accept_latency: tx=%b ready=%b busy=%b, required tx=0 ready=0 busy=1",
               tx, bus.ready, busy);
    end
  endtask

  task automatic rx_char(input int k);
    logic [7:0] got;
    logic [7:0] expb;
    logic       par;
    logic       stp;
    par = 1'b0;
    checks++;
    if (tx !== 1'b0 || bus.ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_bit char %0d: tx=%b ready=%b busy=%b, required 0 0 1",
               k, tx, bus.ready, busy);
    end
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(negedge clock);
      got[i] = tx;
    end
`ifdef LAP_TX_PARITY_EN
    repeat (C) @(negedge clock);
    par = tx;
`endif
    repeat (C) @(negedge clock);
    stp = tx;
    repeat (C) @(negedge clock);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty char %0d: got %02h, required nothing pending", k, got);
    end else begin
      expb = exp_q.pop_front();
      if (got !== expb) begin
        failures++;
        $display("FAIL char_byte %0d: got %02h, required %02h", k, got, expb);
      end else begin
        $display("rx char %0d: %02h", k, got);
      end
`ifdef LAP_TX_PARITY_EN
      checks++;
      if (par !== ^expb) begin
        failures++;
        $display("FAIL parity_bit char %0d: got %b, required %b", k, par, ^expb);
      end
`endif
    end
    checks++;
    if (stp !== 1'b1) begin
      failures++;
      $display("FAIL stop_bit char %0d: got %b, required 1", k, stp);
    end
  endtask

  // Decodes 13 characters back to back, then checks the single idle cycle after the frame.
  task automatic rx_frame();
    for (int k = 0; k < 13; k++) rx_char(k);
    checks++;
    if (tx !== 1'b1 || bus.ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL frame_end: tx=%b ready=%b busy=%b after %0d cycles, required 1 1 0",
               tx, bus.ready, busy, 13 * BITS_PER_CHAR * C);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    bus.valid  = 1'b0;
    bus.digits = '0;
    repeat (3) @(negedge clock);
    checks++;
    if (tx !== 1'b1 || bus.ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: tx=%b ready=%b busy=%b, required 1 1 0", tx, bus.ready, busy);
    end
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      checks++;
      if (tx !== 1'b1 || bus.ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold cycle %0d: tx=%b ready=%b busy=%b, required 1 1 0",
                 i, tx, bus.ready, busy);
      end
    end
  endtask

  task automatic test_basic_frame();
    push_table(t2_bytes);
    offer(32'h1234_5678);
    rx_frame();
  endtask

  task automatic test_invalid_digits();
    push_table(t3_bytes);
    offer(32'h0A00_00F9);
    rx_frame();
  endtask

  task automatic test_back_to_back();
    push_table(t2_bytes);
    offer(32'h1234_5678);
    bus.valid  = 1'b1;
    bus.digits = 32'h9999_9999;
    push_model(32'h9999_9999);
    rx_frame();
    @(negedge clock);
    bus.valid  = 1'b0;
    bus.digits = $urandom;
    checks++;
    if (tx !== 1'b0 || bus.ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap: tx=%b ready=%b one cycle after frame, required tx=0 ready=0",
               tx, bus.ready);
    end
    rx_frame();
  endtask

  task automatic test_reset_mid_frame();
    int offs [2];
    offs[0] = 450;
    offs[1] = BITS_PER_CHAR * C;
    for (int r = 0; r < 2; r++) begin
      push_model(32'h2359_5999);
      offer(32'h2359_5999);
      repeat (offs[r]) @(negedge clock);
      if (r == 1) begin
        checks++;
        if (tx !== 1'b0) begin
          failures++;
          $display("FAIL pre_reset_start: tx=%b at cycle %0d, required 0", tx, offs[r]);
        end
      end
      reset = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1 || bus.ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_frame at %0d: tx=%b ready=%b busy=%b, required 1 1 0",
                 offs[r], tx, bus.ready, busy);
      end
      exp_q.delete();
      repeat (2) @(negedge clock);
      reset = 1'b1;
      push_model(32'h0000_0001);
      offer(32'h0000_0001);
      rx_frame();
    end
  endtask

`ifdef LAP_TX_PARITY_EN
  task automatic test_parity();
    push_model(32'h1100_0000);
    offer(32'h1100_0000);
    rx_frame();
  endtask
`endif

  initial begin
    bus.valid  = 1'b0;
    bus.digits = '0;
    test_reset();
    test_basic_frame();
    test_invalid_digits();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef LAP_TX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: %0d chars pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
